// File: rtl/float_pkg.sv
// float_pkg: shared widths, FSM states and constant words for the mini-float units
package float_pkg;
  localparam int DEF_EXP_W = 3;
  localparam int DEF_MAN_W = 5;
  localparam int WORD_W = DEF_EXP_W + DEF_MAN_W;
  localparam logic [WORD_W-1:0] SAT_WORD = '1;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;
endpackage

// File: rtl/float_order.sv
// float_order: picks the larger-exponent operand (A on a tie) and the exponent gap
module float_order
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W-1:0] a_i,
  input  logic [EXP_W+MAN_W-1:0] b_i,
  output logic [EXP_W-1:0]       big_exp_o,
  output logic [MAN_W-1:0]       big_man_o,
  output logic [MAN_W-1:0]       small_man_o,
  output logic [EXP_W-1:0]       d_o
);
  logic [EXP_W-1:0] a_e, b_e;
  logic swap;
  assign a_e = a_i[EXP_W+MAN_W-1:MAN_W];
  assign b_e = b_i[EXP_W+MAN_W-1:MAN_W];
  assign swap = b_e > a_e;
  assign big_exp_o = swap ? b_e : a_e;
  assign big_man_o = swap ? b_i[MAN_W-1:0] : a_i[MAN_W-1:0];
  assign small_man_o = swap ? a_i[MAN_W-1:0] : b_i[MAN_W-1:0];
  assign d_o = swap ? b_e - a_e : a_e - b_e;
endmodule

// File: rtl/float_add_seq.sv
// float_add_seq: multi-cycle mini-float adder with bit-serial align and normalise
module float_add_seq
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] a_in,
  input  logic [EXP_W+MAN_W-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   out_sat
);
  state_e state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d, cnt_q, cnt_d, o_exp, o_d;
  logic [MAN_W-1:0] man_q, man_d, sm_q, sm_d, o_big, o_small;
  logic sat_q, sat_d, go, far;
  logic [MAN_W:0] sum;
  float_order #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_order (
    .a_i(a_in),
    .b_i(b_in),
    .big_exp_o(o_exp),
    .big_man_o(o_big),
    .small_man_o(o_small),
    .d_o(o_d)
  );
  assign in_ready = state_q == IDLE && !reset;
  assign go = in_valid && in_ready;
  assign far = 32'(o_d) >= MAN_W;
  assign sum = {1'b0, man_q} + {1'b0, sm_q};
  assign out_valid = state_q == DONE;
  // exp_q/man_q double as the working registers and the committed result
  assign result = {exp_q, man_q};
  assign out_sat = sat_q;
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    man_d = man_q;
    sm_d = sm_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: if (go) begin
        exp_d = o_exp;
        man_d = o_big;
        sm_d = far ? '0 : o_small;
        cnt_d = far ? '0 : o_d;
        sat_d = 1'b0;
        state_d = (far || o_d == '0) ? ADD : ALIGN;
      end
      ALIGN: begin
        sm_d = sm_q >> 1;
        cnt_d = cnt_q - EXP_W'(1);
        state_d = cnt_q == EXP_W'(1) ? ADD : ALIGN;
      end
      ADD: begin
        state_d = NORM;
        if (sum[MAN_W] && &exp_q) begin
          exp_d = '1;
          man_d = '1;
          sat_d = 1'b1;
          state_d = DONE;
        end else if (sum[MAN_W]) begin
          man_d = sum[MAN_W:1];
          exp_d = exp_q + EXP_W'(1);
        end else if (sum[MAN_W-1:0] == '0) begin
          man_d = '0;
          exp_d = '0;
          state_d = DONE;
        end else man_d = sum[MAN_W-1:0];
      end
      NORM: if (man_q[MAN_W-1] || exp_q == '0) state_d = DONE;
      else begin
        man_d = man_q << 1;
        exp_d = exp_q - EXP_W'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      exp_q <= '0;
      man_q <= '0;
      sm_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      man_q <= man_d;
      sm_q <= sm_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_float_add_seq.sv
// tb_float_add_seq: directed and randomized checks of float_add_seq against an arithmetic model
module tb_float_add_seq;
  localparam int EW = 3;
  localparam int MW = 5;
  localparam int W = EW + MW;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [W-1:0] a_in, b_in, result;
  int checks = 0;
  int errors = 0;
  float_add_seq #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_in(a_in),
    .b_in(b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  // value = man * 2^exp; latency counts edges from the handshake edge to out_valid
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic s, output int lat);
    int ea, ma, eb, mb, eg, mg, msm, d, dp, sum, e, m, k;
    ea = int'(a[W-1:MW]); ma = int'(a[MW-1:0]);
    eb = int'(b[W-1:MW]); mb = int'(b[MW-1:0]);
    if (eb > ea) begin eg = eb; mg = mb; msm = ma; d = eb - ea; end
    else begin eg = ea; mg = ma; msm = mb; d = ea - eb; end
    dp = (d >= MW) ? 0 : d;
    msm = (d >= MW) ? 0 : msm / (2 ** d);
    sum = mg + msm;
    e = eg;
    s = 1'b0;
    k = 0;
    if (sum >= 2 ** MW) begin
      if (e == 2 ** EW - 1) begin
        s = 1'b1; r = W'(2 ** W - 1); lat = 2 + dp;
        return;
      end
      e = e + 1; m = sum / 2;
    end else m = sum;
    if (m == 0) begin
      r = '0; lat = 2 + dp;
      return;
    end
    while (m < 2 ** (MW - 1) && e > 0) begin
      m = m * 2; e = e - 1; k++;
    end
    r = W'(e * (2 ** MW) + m);
    lat = 3 + dp + k;
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall, input bit noise,
                        input logic [W-1:0] er, input logic es, input int el);
    int lat;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b0;
    chk("idle_ready", in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    chk("sat_clear", out_sat, 0);
    if (noise) begin a_in = W'($urandom); b_in = W'($urandom); end
    else in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      chk("busy_ready", in_ready, 0);
      @(posedge clk); lat++; @(negedge clk);
    end
    in_valid = 1'b0;
    chk("latency", lat, el);
    chk("result", result, er);
    chk("sat", out_sat, es);
    repeat (stall) begin
      @(posedge clk); @(negedge clk);
      chk("hold_result", result, er);
      chk("hold_sat", out_sat, es);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask
  initial begin
    logic [W-1:0] ra, rb, er;
    logic es;
    int el;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);
    run_op(8'h48, 8'h24, 0, 0, 8'h34, 1'b0, 5);
    run_op(8'h30, 8'h30, 1, 0, 8'h50, 1'b0, 3);
    run_op(8'hF0, 8'hF0, 2, 0, 8'hFF, 1'b1, 2);
    run_op(8'h00, 8'h00, 0, 0, 8'h00, 1'b0, 2);
    run_op(8'h1F, 8'hE1, 0, 1, 8'h70, 1'b0, 7);
    run_op(8'h02, 8'h01, 10, 0, 8'h03, 1'b0, 3);
    // abort during NORM: three edges after the handshake the 0x48+0x24 op is normalising
    @(negedge clk);
    a_in = 8'h48; b_in = 8'h24; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_valid", out_valid, 0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_ready_rst", in_ready, 0);
    reset = 1'b0;
    #1 chk("abort_ready", in_ready, 1);
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb[W-1:MW] = ra[W-1:MW];
      model(ra, rb, er, es, el);
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), er, es, el);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
